// File: rtl/seg7_scan_driver_pkg.sv
// Segment encoding shared by the 7-segment scan driver and its decoder.
// Segment vectors are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg7_scan_driver_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side data/control and display-side pins of the 7-segment scan driver.
// master = host/bench driving the values, slave = the driver itself.
interface seg7_scan_driver_if #(
  parameter int NDIGITS = 4
);
  logic [4*NDIGITS-1:0] value;
  logic [NDIGITS-1:0]   dp;
  logic [NDIGITS-1:0]   blank;
  logic                 load;
  logic [3:0]           duty;
  logic [NDIGITS-1:0]   an;
  logic [6:0]           seg;
  logic                 dp_n;
  logic                 frame;
  logic                 pending;

  modport master (
    output value, dp, blank, load, duty,
    input  an, seg, dp_n, frame, pending
  );

  modport slave (
    input  value, dp, blank, load, duty,
    output an, seg, dp_n, frame, pending
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one digit per slot, shadow
// buffer swapped only at the frame boundary, dead time and 16-step PWM per slot.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int NDELAY  = 50000,
  parameter int NBITS   = 16,
  parameter int DEAD    = 500
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int                DIGW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int                SLICE      = NDELAY / 16;
  localparam logic [NBITS-1:0]  LAST_COUNT = NBITS'(NDELAY - 1);
  localparam logic [DIGW-1:0]   LAST_DIGIT = DIGW'(NDIGITS - 1);
  localparam logic [NBITS-1:0]  DEAD_C     = NBITS'(DEAD);
  localparam logic [NBITS-1:0]  SLICE_C    = NBITS'(SLICE);

  logic [NBITS-1:0]     count_q, count_d;
  logic [DIGW-1:0]      digit_q, digit_d;
  logic [3:0]           duty_q, duty_d;
  logic [4*NDIGITS-1:0] pend_value_q, pend_value_d;
  logic [NDIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NDIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                 pending_q, pending_d;
  logic [4*NDIGITS-1:0] shadow_value_q, shadow_value_d;
  logic [NDIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NDIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [NDIGITS-1:0]   an_q, an_d;
  seg_t                 seg_q, seg_d;
  logic                 dp_n_q, dp_n_d;
  logic                 frame_q, frame_d;

  logic                 slot_end;
  logic                 frame_end;
  logic [NBITS-1:0]     thresh;
  logic                 lit;
  logic [3:0]           cur_nibble;
  seg_t                 cur_seg;

  assign cur_nibble = shadow_value_q[{digit_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    slot_end  = (count_q == LAST_COUNT);
    frame_end = slot_end && (digit_q == LAST_DIGIT);

    count_d = slot_end ? '0 : count_q + NBITS'(1);
    digit_d = digit_q;
    if (slot_end) begin
      digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIGW'(1);
    end
    // Brightness is latched per slot so a slot never mixes two duty levels.
    duty_d = slot_end ? bus.duty : duty_q;

    pend_value_d   = pend_value_q;
    pend_dp_d      = pend_dp_q;
    pend_blank_d   = pend_blank_q;
    pending_d      = pending_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;

    if (bus.load) begin
      pend_value_d = bus.value;
      pend_dp_d    = bus.dp;
      pend_blank_d = bus.blank;
      // A load landing on the boundary bypasses the pending stage entirely.
      if (frame_end) begin
        shadow_value_d = bus.value;
        shadow_dp_d    = bus.dp;
        shadow_blank_d = bus.blank;
        pending_d      = 1'b0;
      end else begin
        pending_d      = 1'b1;
      end
    end else if (frame_end && pending_q) begin
      shadow_value_d = pend_value_q;
      shadow_dp_d    = pend_dp_q;
      shadow_blank_d = pend_blank_q;
      pending_d      = 1'b0;
    end

    thresh = NBITS'(duty_q) * SLICE_C;
    lit    = (count_q >= DEAD_C) && (duty_q != 4'd0) &&
             ((duty_q == 4'd15) || (count_q < thresh)) &&
             !shadow_blank_q[digit_q];

    an_d   = '1;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    if (lit) begin
      an_d[digit_q] = 1'b0;
      seg_d         = cur_seg;
      dp_n_d        = ~shadow_dp_q[digit_q];
    end
    frame_d = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q        <= '0;
      digit_q        <= '0;
      duty_q         <= '0;
      pend_value_q   <= '0;
      pend_dp_q      <= '0;
      pend_blank_q   <= '0;
      pending_q      <= 1'b0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      an_q           <= '1;
      seg_q          <= SEG_OFF;
      dp_n_q         <= 1'b1;
      frame_q        <= 1'b0;
    end else begin
      count_q        <= count_d;
      digit_q        <= digit_d;
      duty_q         <= duty_d;
      pend_value_q   <= pend_value_d;
      pend_dp_q      <= pend_dp_d;
      pend_blank_q   <= pend_blank_d;
      pending_q      <= pending_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_n_q         <= dp_n_d;
      frame_q        <= frame_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.dp_n    = dp_n_q;
  assign bus.frame   = frame_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: table of display vectors, hand-written boundary
// sequences and a random run checked every cycle against a cycle-index model.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int NDL   = 32;
  localparam int NB    = 6;
  localparam int DEAD  = 1;
  localparam int SLICE = NDL / 16;
  localparam int FRAME = NDL * ND;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_driver_if #(.NDIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NDIGITS (ND),
    .NDELAY  (NDL),
    .NBITS   (NB),
    .DEAD    (DEAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [16];

  // Model: time is an absolute cycle index k since reset release.
  int         k;
  int         m_duty;
  logic [3:0] sh_nib [ND];
  logic       sh_dp [ND];
  logic       sh_blank [ND];
  logic [3:0] pd_nib [ND];
  logic       pd_dp [ND];
  logic       pd_blank [ND];
  logic       m_pending;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dpn, e_frame, e_pend;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  duty;
    int          dig;
    int          on;
    logic [6:0]  seg;
    logic        dpn;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_duty = 0;
    m_pending = 1'b0;
    for (int d = 0; d < ND; d++) begin
      sh_nib[d] = '0; sh_dp[d] = 1'b0; sh_blank[d] = 1'b0;
      pd_nib[d] = '0; pd_dp[d] = 1'b0; pd_blank[d] = 1'b0;
    end
    e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_frame = 1'b0; e_pend = 1'b0;
  endtask

  task automatic model_edge();
    int cnt, dig;
    bit lit, slot_end, boundary;
    cnt = k % NDL;
    dig = (k / NDL) % ND;
    lit = (cnt >= DEAD) && (m_duty != 0) && (m_duty == 15 || cnt < m_duty * SLICE) && !sh_blank[dig];
    e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
    if (lit) begin
      e_an[dig] = 1'b0;
      e_seg     = seg_tab[sh_nib[dig]];
      e_dpn     = ~sh_dp[dig];
    end
    slot_end = ((k + 1) % NDL) == 0;
    boundary = ((k + 1) % FRAME) == 0;
    e_frame  = boundary;
    if (bus.load) begin
      for (int d = 0; d < ND; d++) begin
        if (boundary) begin
          sh_nib[d] = bus.value[4*d +: 4]; sh_dp[d] = bus.dp[d]; sh_blank[d] = bus.blank[d];
        end else begin
          pd_nib[d] = bus.value[4*d +: 4]; pd_dp[d] = bus.dp[d]; pd_blank[d] = bus.blank[d];
        end
      end
      m_pending = !boundary;
    end else if (boundary && m_pending) begin
      for (int d = 0; d < ND; d++) begin
        sh_nib[d] = pd_nib[d]; sh_dp[d] = pd_dp[d]; sh_blank[d] = pd_blank[d];
      end
      m_pending = 1'b0;
    end
    if (slot_end) m_duty = int'(bus.duty);
    e_pend = m_pending;
    k++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    if (!rst)
      check("cycle", {bus.an, bus.seg, bus.dp_n, bus.frame, bus.pending},
                     {e_an, e_seg, e_dpn, e_frame, e_pend});
  endtask

  task automatic wait_frame(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (bus.frame === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Called from a falling edge; reset rises mid-phase to exercise the async path.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check("async_reset", {bus.an, bus.seg, bus.dp_n, bus.frame, bus.pending},
                            {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    model_reset();
    bus.load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int n, on;
    logic [6:0] sseg;
    logic sdp;
    logic [3:0] an_sel;

    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110;
    seg_tab[15] = 7'b0001110;

    //            value     dp       blank    duty  dig on  seg          dp_n
    vecs[0]  = '{16'h8A10, 4'b0001, 4'b0000, 4'd15, 0, 31, 7'b1000000, 1'b0};
    vecs[1]  = '{16'h8A10, 4'b0001, 4'b0000, 4'd15, 1, 31, 7'b1111001, 1'b1};
    vecs[2]  = '{16'h8A10, 4'b0001, 4'b0000, 4'd15, 2, 31, 7'b0001000, 1'b1};
    vecs[3]  = '{16'h8A10, 4'b0001, 4'b0000, 4'd15, 3, 31, 7'b0000000, 1'b1};
    vecs[4]  = '{16'h0005, 4'b0000, 4'b0000, 4'd4,  0, 7,  7'b0010010, 1'b1};
    vecs[5]  = '{16'h0005, 4'b0000, 4'b0000, 4'd0,  0, 0,  7'b1111111, 1'b1};
    vecs[6]  = '{16'h3456, 4'b1111, 4'b0100, 4'd15, 2, 0,  7'b1111111, 1'b1};
    vecs[7]  = '{16'h3456, 4'b1111, 4'b0100, 4'd15, 3, 31, 7'b0110000, 1'b0};
    vecs[8]  = '{16'hBCDE, 4'b0000, 4'b0000, 4'd1,  0, 1,  7'b0000110, 1'b1};
    vecs[9]  = '{16'hBCDE, 4'b0010, 4'b0000, 4'd14, 1, 27, 7'b0100001, 1'b0};
    vecs[10] = '{16'h7F96, 4'b0000, 4'b0000, 4'd8,  2, 15, 7'b0001110, 1'b1};
    vecs[11] = '{16'h7F96, 4'b1000, 4'b0000, 4'd15, 3, 31, 7'b1111000, 1'b0};
    vecs[12] = '{16'h4320, 4'b0000, 4'b0000, 4'd15, 1, 31, 7'b0100100, 1'b1};
    vecs[13] = '{16'h4320, 4'b0000, 4'b0000, 4'd15, 3, 31, 7'b0011001, 1'b1};
    vecs[14] = '{16'h7F96, 4'b0000, 4'b0000, 4'd15, 1, 31, 7'b0010000, 1'b1};
    vecs[15] = '{16'hBCDE, 4'b0000, 4'b0000, 4'd15, 2, 31, 7'b1000110, 1'b1};

    bus.value = '0; bus.dp = '0; bus.blank = '0; bus.load = 1'b0; bus.duty = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Scan period from reset release.
    wait_frame(200, n);
    check("first_frame_clocks", n, FRAME);
    wait_frame(200, n);
    check("frame_period", n, FRAME);
    $display("[TB] frame period check: %0d clocks", n);

    // Table vectors: load, wait for the swap, then watch one digit's slot.
    for (int i = 0; i < 16; i++) begin
      bus.value = vecs[i].value; bus.dp = vecs[i].dp; bus.blank = vecs[i].blank;
      bus.duty = vecs[i].duty; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      wait_frame(300, n);
      repeat (vecs[i].dig * NDL) tick();
      an_sel = 4'hF;
      an_sel[vecs[i].dig] = 1'b0;
      on = 0; sseg = 7'h7F; sdp = 1'b1;
      repeat (NDL) begin
        tick();
        if (bus.an === an_sel) begin
          on++;
          sseg = bus.seg;
          sdp  = bus.dp_n;
        end
      end
      check($sformatf("vec%0d", i), {1'(n >= 0), 8'(on), sseg, sdp},
            {1'b1, 8'(vecs[i].on), vecs[i].seg, vecs[i].dpn});
      $display("[TB] vec %0d value=%h digit=%0d duty=%0d lit=%0d seg=%b dp_n=%b",
               i, vecs[i].value, vecs[i].dig, vecs[i].duty, on, sseg, sdp);
    end

    // Two loads in one frame: only the second is shown.
    bus.duty = 4'd15; bus.dp = '0; bus.blank = '0;
    wait_frame(300, n);
    repeat (5) tick();
    bus.value = 16'h1111; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("pending_after_load1", bus.pending, 1'b1);
    repeat (10) tick();
    bus.value = 16'h2222; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("pending_after_load2", bus.pending, 1'b1);
    wait_frame(200, n);
    check("pending_after_swap", {1'(n >= 0), bus.pending}, {1'b1, 1'b0});
    repeat (2) tick();
    check("two_loads_digit0", {bus.an, bus.seg}, {4'b1110, 7'b0100100});
    $display("[TB] double load: digit0 an=%b seg=%b", bus.an, bus.seg);

    // Load landing exactly on the frame-boundary edge.
    wait_frame(200, n);
    repeat (FRAME - 1) tick();
    bus.value = 16'h000C; bus.dp = 4'b0001; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("load_on_boundary", {bus.frame, bus.pending}, {1'b1, 1'b0});
    repeat (2) tick();
    check("boundary_load_shown", {bus.an, bus.seg, bus.dp_n}, {4'b1110, 7'b1000110, 1'b0});
    $display("[TB] boundary load: frame/pending ok path, digit0 seg=%b", bus.seg);

    // Duty dropped mid-slot keeps the current slot, darkens the next.
    bus.dp = '0;
    wait_frame(200, n);
    repeat (11) tick();
    bus.duty = 4'd0;
    on = 0;
    repeat (NDL - 11) begin
      tick();
      if (bus.an !== 4'hF) on++;
    end
    n = 0;
    repeat (NDL) begin
      tick();
      if (bus.an !== 4'hF) n++;
    end
    check("duty_mid_slot", {8'(on), 8'(n)}, {8'd21, 8'd0});
    $display("[TB] duty change mid-slot: lit %0d rest of slot, %0d next slot", on, n);

    // Reset while a digit is lit, then scanning restarts cleanly.
    bus.duty = 4'd15;
    wait_frame(200, n);
    repeat (5) tick();
    do_reset();
    wait_frame(200, n);
    check("frame_after_reset", n, FRAME);
    $display("[TB] reset mid-slot: first frame after %0d clocks", n);

    // Random traffic against the model, with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      bus.load = ($urandom_range(0, 29) == 0);
      if (bus.load) begin
        bus.value = 16'($urandom);
        bus.dp    = 4'($urandom);
        bus.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(0, 39) == 0) bus.duty = 4'($urandom_range(0, 15));
      if (i == 700) do_reset();
      tick();
    end
    bus.load = 1'b0;
    $display("[TB] random run finished at model cycle %0d", k);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
